// File: rtl/clock_time_keeper_if.sv
// Tick/load bus between the tick generator side and the clock time keeper.
// The master drives ticks and loads. The slave returns BCD time and status pulses.
interface clock_time_keeper_if;
  logic        one_min;
  logic        load_new_c;
  logic [15:0] new_time;
  logic [15:0] cur_time;
  logic        reset_count;
  logic        day_wrap;
  logic        load_err;

  modport master (
    output one_min, load_new_c, new_time,
    input  cur_time, reset_count, day_wrap, load_err
  );

  modport slave (
    input  one_min, load_new_c, new_time,
    output cur_time, reset_count, day_wrap, load_err
  );
endinterface

// File: rtl/clock_time_keeper.sv
// 24-hour BCD HH:MM keeper. It counts rising edges of one_min and accepts validated loads.
// Every output is registered. On a load it pulses reset_count so the generator realigns.
module clock_time_keeper (
  input  logic                 clk,
  input  logic                 reset,
  clock_time_keeper_if.slave   bus
);
  logic        r_one_min_d;
  logic [15:0] r_cur_time;
  logic        r_reset_count;
  logic        r_day_wrap;
  logic        r_load_err;

  logic        w_tick;
  logic        w_valid;
  logic        w_wrap;
  logic [3:0]  w_ht, w_ho, w_mt, w_mo;
  logic [3:0]  w_nht, w_nho, w_nmt, w_nmo;

  assign w_tick = bus.one_min & ~r_one_min_d;

  assign w_valid = (bus.new_time[15:12] <= 4'd2) &&
                   (bus.new_time[11:8]  <= 4'd9) &&
                   !((bus.new_time[15:12] == 4'd2) && (bus.new_time[11:8] > 4'd3)) &&
                   (bus.new_time[7:4]   <= 4'd5) &&
                   (bus.new_time[3:0]   <= 4'd9);

  assign {w_ht, w_ho, w_mt, w_mo} = r_cur_time;

  // Single-cycle ripple of BCD carries. Only valid states are ever held, so no range guards are needed.
  always_comb begin
    w_nht  = w_ht;
    w_nho  = w_ho;
    w_nmt  = w_mt;
    w_nmo  = w_mo;
    w_wrap = 1'b0;
    if (w_mo != 4'd9) begin
      w_nmo = w_mo + 4'd1;
    end else begin
      w_nmo = 4'd0;
      if (w_mt != 4'd5) begin
        w_nmt = w_mt + 4'd1;
      end else begin
        w_nmt = 4'd0;
        if (w_ht == 4'd2 && w_ho == 4'd3) begin
          w_nht  = 4'd0;
          w_nho  = 4'd0;
          w_wrap = 1'b1;
        end else if (w_ho == 4'd9) begin
          w_nho = 4'd0;
          w_nht = w_ht + 4'd1;
        end else begin
          w_nho = w_ho + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_one_min_d   <= 1'b0;
      r_cur_time    <= 16'h0000;
      r_reset_count <= 1'b0;
      r_day_wrap    <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_one_min_d   <= bus.one_min;
      r_reset_count <= 1'b0;
      r_day_wrap    <= 1'b0;
      r_load_err    <= 1'b0;
      // A load in the same cycle as a tick discards the tick. The tick is not replayed later.
      if (bus.load_new_c) begin
        if (w_valid) begin
          r_cur_time    <= bus.new_time;
          r_reset_count <= 1'b1;
        end else begin
          r_load_err    <= 1'b1;
        end
      end else if (w_tick) begin
        r_cur_time <= {w_nht, w_nho, w_nmt, w_nmo};
        r_day_wrap <= w_wrap;
      end
    end
  end

  assign bus.cur_time    = r_cur_time;
  assign bus.reset_count = r_reset_count;
  assign bus.day_wrap    = r_day_wrap;
  assign bus.load_err    = r_load_err;
endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed scoreboard bench for clock_time_keeper.
// Each step queues its expected outputs, clocks once, then pops the entry and compares.
module tb_clock_time_keeper;
  logic clk = 1'b0;
  logic reset;
  clock_time_keeper_if bus ();

  clock_time_keeper dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] cur;
    logic        rc;
    logic        dw;
    logic        le;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic step(input logic rst, input logic om, input logic ld, input logic [15:0] nt,
                      input logic [15:0] e_cur, input logic e_rc, input logic e_dw,
                      input logic e_le, input string tag);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    bus.one_min    = om;
    bus.load_new_c = ld;
    bus.new_time   = nt;
    e.tag = tag; e.cur = e_cur; e.rc = e_rc; e.dw = e_dw; e.le = e_le;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".cur"}, bus.cur_time, e.cur);
    check({e.tag, ".rc"},  {15'd0, bus.reset_count}, {15'd0, e.rc});
    check({e.tag, ".dw"},  {15'd0, bus.day_wrap},    {15'd0, e.dw});
    check({e.tag, ".le"},  {15'd0, bus.load_err},    {15'd0, e.le});
  endtask

  initial begin
    reset = 1'b1;
    bus.one_min = 1'b0;
    bus.load_new_c = 1'b0;
    bus.new_time = 16'h0000;

    step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "rst0");
    step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "rst1");

    // Three single-cycle pulses.
    step(0, 1, 0, 16'h0000, 16'h0001, 0, 0, 0, "p1");
    step(0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, "p1lo");
    step(0, 1, 0, 16'h0000, 16'h0002, 0, 0, 0, "p2");
    step(0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0, "p2lo");
    step(0, 1, 0, 16'h0000, 16'h0003, 0, 0, 0, "p3");
    step(0, 0, 0, 16'h0000, 16'h0003, 0, 0, 0, "p3lo");

    // Holding one_min high for 20 cycles gives exactly one increment.
    step(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "fw_rst");
    step(0, 1, 0, 16'h0000, 16'h0001, 0, 0, 0, "fw0");
    for (int i = 1; i < 20; i++)
      step(0, 1, 0, 16'h0000, 16'h0001, 0, 0, 0, "fw_hold");
    step(0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, "fw_rel");

    // Day wrap from 23:59.
    step(0, 0, 1, 16'h2359, 16'h2359, 1, 0, 0, "ld2359");
    step(0, 0, 0, 16'h0000, 16'h2359, 0, 0, 0, "ld2359_idle");
    step(0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, "wrap");
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "wrap_after");

    // Hour carries.
    step(0, 0, 1, 16'h0959, 16'h0959, 1, 0, 0, "ld0959");
    step(0, 1, 0, 16'h0000, 16'h1000, 0, 0, 0, "to1000");
    step(0, 0, 1, 16'h1959, 16'h1959, 1, 0, 0, "ld1959");
    step(0, 1, 0, 16'h0000, 16'h2000, 0, 0, 0, "to2000");
    step(0, 0, 0, 16'h0000, 16'h2000, 0, 0, 0, "idle2000");

    // Rejected loads leave the time unchanged and do not pulse reset_count.
    step(0, 0, 1, 16'h2400, 16'h2000, 0, 0, 1, "bad2400");
    step(0, 0, 0, 16'h0000, 16'h2000, 0, 0, 0, "bad2400_after");
    step(0, 0, 1, 16'h1260, 16'h2000, 0, 0, 1, "bad1260");
    step(0, 0, 0, 16'h0000, 16'h2000, 0, 0, 0, "bad1260_after");
    step(0, 0, 1, 16'h0A00, 16'h2000, 0, 0, 1, "bad0A00");
    step(0, 0, 0, 16'h0000, 16'h2000, 0, 0, 0, "bad0A00_after");
    // A rejected load also discards a coincident tick.
    step(0, 1, 1, 16'h2400, 16'h2000, 0, 0, 1, "bad_tick");
    step(0, 0, 0, 16'h0000, 16'h2000, 0, 0, 0, "bad_tick_after");

    // A load wins over a coincident rising edge, and a held one_min does not re-trigger.
    step(0, 1, 1, 16'h1234, 16'h1234, 1, 0, 0, "ld_tick");
    step(0, 1, 0, 16'h0000, 16'h1234, 0, 0, 0, "ld_tick_hold");
    step(0, 0, 0, 16'h0000, 16'h1234, 0, 0, 0, "ld_tick_rel");

    // A load held for three cycles keeps reset_count high for all three.
    step(0, 0, 1, 16'h0815, 16'h0815, 1, 0, 0, "hold_ld0");
    step(0, 1, 1, 16'h0815, 16'h0815, 1, 0, 0, "hold_ld1");
    step(0, 1, 1, 16'h0815, 16'h0815, 1, 0, 0, "hold_ld2");
    step(0, 0, 0, 16'h0000, 16'h0815, 0, 0, 0, "hold_ld_rel");

    // Reset beats a coincident load and tick. one_min_d clears, so a held one_min then ticks.
    step(1, 1, 1, 16'h0959, 16'h0000, 0, 0, 0, "rst_ld_tick");
    step(0, 1, 0, 16'h0000, 16'h0001, 0, 0, 0, "post_rst_tick");
    step(0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, "post_rst_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/clock_time_keeper.md
# clock_time_keeper

Receiving end of the tick interface from the seconds/minutes tick generator. Counts `one_min` rising edges into a 24-hour BCD time (HH:MM) and accepts a validated new-time load. On a load it drives the generator's `reset_count` input so the seconds phase restarts aligned to the loaded minute. Its outputs feed the display and alarm-compare logic.

## Interface
Parameters: none; the 24-hour BCD format is fixed.

Ports:
- clk  in  1  system clock; same clock as the tick generator
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- one_min  in  1  minute tick from the generator; may stay high more than one cycle (fastwatch mode)
- load_new_c  in  1  load strobe for new time; level-sampled every cycle
- new_time  in  16  {hr_tens, hr_ones, min_tens, min_ones}, 4-bit BCD each
- cur_time  out  16  {hr_tens, hr_ones, min_tens, min_ones}, registered BCD
- reset_count  out  1  to the generator; high for one cycle per accepted load cycle
- day_wrap  out  1  one-cycle pulse when time rolls 23:59 → 00:00
- load_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Edge detect: register `one_min_d`, reset value 0, updated every cycle including during a load.
  - A tick is `one_min & ~one_min_d`.
  - One tick gives exactly one increment, however long `one_min` stays high.
- Load validity. A load is valid when all of these hold:
  - hr_tens ≤ 2.
  - hr_ones ≤ 9, and hr_ones ≤ 3 when hr_tens = 2.
  - min_tens ≤ 5.
  - min_ones ≤ 9.
- Per-cycle priority, highest first:
  1. reset: cur_time = 16'h0000; reset_count, day_wrap, load_err = 0; one_min_d = 0.
  2. `load_new_c` with valid data: cur_time ← new_time; reset_count ← 1; the tick in this cycle is discarded, not deferred.
  3. `load_new_c` with invalid data: cur_time held; load_err ← 1; reset_count ← 0; the tick in this cycle is also discarded.
  4. Tick: BCD increment of cur_time.
  5. Otherwise: hold.
- reset_count, day_wrap and load_err are registered. Each is 0 in any cycle where its condition does not occur.
- BCD increment rules:
  - min_ones 9 → 0, carry to min_tens; otherwise +1.
  - min_tens 5 with carry → 0, carry to hours.
  - Hours 23 with carry → 00, and day_wrap ← 1.
  - Hours x9 with carry → (x+1)0.
  - Otherwise hr_ones +1.
  - Pure next-state logic from cur_time; no multi-cycle arithmetic.
- Increment is defined only from valid states. The block never reaches an invalid state, because reset and loads are the only entries and both give valid values.
- `load_new_c` held for N cycles with valid data: cur_time reloaded each cycle and reset_count high for the same N cycles. The generator therefore stays cleared until release.

## Timing
- Reset value of every output is 0 (cur_time = 00:00).
- Tick latency: `one_min` seen high (with `one_min_d` = 0) at edge k → cur_time updated at edge k, visible from cycle k+1. `one_min_d` = 1 from edge k.
- Load latency: `load_new_c` sampled high at edge k → cur_time = new_time and reset_count = 1 from edge k, both for one cycle per sampled-high cycle.
  - The generator sees reset_count at edge k+1, so its counting restarts one cycle after the load.
- day_wrap is asserted during the cycle in which cur_time first shows 00:00 after the wrap.
- load_err is asserted during the cycle after the rejected sample.
- Reset mid-load or mid-tick: reset wins. All state returns to reset values at that edge, and no pulse is emitted.
- No combinational path from any input to any output.

## Test plan
- Reset then 3 single-cycle `one_min` pulses → cur_time 16'h0003; day_wrap and load_err stay 0.
- `one_min` held high 20 cycles (fastwatch-style) → exactly one increment, 00:00 → 00:01.
- Load 16'h2359 (reset_count = 1 for one cycle), then one tick → cur_time 16'h0000 with day_wrap = 1 for exactly one cycle. Also check 09:59 → 10:00 and 19:59 → 20:00.
- Invalid loads 16'h2400, 16'h1260 and 16'h0A00 → each gives a load_err pulse, cur_time unchanged, reset_count stays 0.
- `load_new_c` with 16'h1234 in the same cycle as a tick rising edge → cur_time 16'h1234, not 12:35. If `one_min` stays high in the next cycle, no further increment occurs.
- Reset asserted in the same cycle as a valid load and a tick → cur_time 16'h0000 and all pulses 0. Integrate with the tick generator and confirm the first post-load `one_min` arrives a full minute period after the load.
